// File: rtl/mvau_pkg.sv
// Shared MVAU definitions: weight-loader state encoding.
package mvau_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    READY = 2'd1,
    ERROR = 2'd2
  } wload_state_t;

endpackage

// File: rtl/mvau_weight_ram.sv
// Simple dual-port weight RAM: one write port, one registered read-first read port.
module mvau_weight_ram #(
  parameter int unsigned SIMD         = 2,
  parameter int unsigned TW           = 1,
  parameter int unsigned WMEM_DEPTH   = 4,
  parameter int unsigned WMEM_ADDR_BW = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic [WMEM_ADDR_BW-1:0] wr_addr_i,
  input  logic [SIMD*TW-1:0]      wr_data_i,
  input  logic [WMEM_ADDR_BW-1:0] rd_addr_i,
  output logic [SIMD*TW-1:0]      rd_data_o
);

  localparam int unsigned DataW = SIMD * TW;
  localparam int unsigned IdxBw = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1;

  (* ram_style = "auto" *) logic [DataW-1:0] mem_q [WMEM_DEPTH];

  logic             wr_in_range;
  logic             rd_in_range;
  logic [DataW-1:0] rd_data_d;
  logic [DataW-1:0] rd_data_q;

  assign wr_in_range = (32'(wr_addr_i) < WMEM_DEPTH);
  assign rd_in_range = (32'(rd_addr_i) < WMEM_DEPTH);

  // Storage array: no reset so contents survive reset and reload.
  always_ff @(posedge clk_i) begin
    if (we_i && wr_in_range) begin
      mem_q[wr_addr_i[IdxBw-1:0]] <= wr_data_i;
    end
  end

  // Read mux; out-of-range addresses return zero.
  always_comb begin
    rd_data_d = '0;
    if (rd_in_range) begin
      rd_data_d = mem_q[rd_addr_i[IdxBw-1:0]];
    end
  end

  // Output register samples pre-write array contents, giving read-first behaviour.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mvau_weight_loader.sv
// Runtime weight loader: AXI-Stream words written sequentially into the PE weight RAM.
module mvau_weight_loader
  import mvau_pkg::*;
#(
  parameter int unsigned SIMD         = 2,
  parameter int unsigned TW           = 1,
  parameter int unsigned WMEM_DEPTH   = 4,
  parameter int unsigned WMEM_ADDR_BW = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [SIMD*TW-1:0]      s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  input  logic                    reload,
  input  logic [WMEM_ADDR_BW-1:0] wmem_addr,
  output logic [SIMD*TW-1:0]      wmem_out,
  output logic                    wmem_valid,
  output logic                    load_err
);

  localparam logic [WMEM_ADDR_BW-1:0] LastAddr = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

  wload_state_t            state_q, state_d;
  logic [WMEM_ADDR_BW-1:0] cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic                    accept;

  // Ready is gated by reset directly so it is low for the whole reset assertion.
  assign s_axis_tready = (state_q == LOAD) && !areset;
  assign accept        = s_axis_tvalid && (state_q == LOAD);

  // Next-state: advance on handshakes, close the set on tlast or on the last address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    err_d   = err_q;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          if (cnt_q == LastAddr) begin
            cnt_d = '0;
            if (s_axis_tlast) begin
              state_d = READY;
              valid_d = 1'b1;
            end else begin
              state_d = ERROR;
              err_d   = 1'b1;
            end
          end else if (s_axis_tlast) begin
            cnt_d   = '0;
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      READY, ERROR: begin
        if (reload) begin
          state_d = LOAD;
          cnt_d   = '0;
          valid_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
        valid_d = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  // FSM, counter and status flags.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign wmem_valid = valid_q;
  assign load_err   = err_q;

  mvau_weight_ram #(
    .SIMD         (SIMD),
    .TW           (TW),
    .WMEM_DEPTH   (WMEM_DEPTH),
    .WMEM_ADDR_BW (WMEM_ADDR_BW)
  ) u_ram (
    .clk_i     (aclk),
    .rst_i     (areset),
    .we_i      (accept),
    .wr_addr_i (cnt_q),
    .wr_data_i (s_axis_tdata),
    .rd_addr_i (wmem_addr),
    .rd_data_o (wmem_out)
  );

endmodule

// File: tb/tb_mvau_weight_loader.sv
// Directed bench for mvau_weight_loader (SIMD=2, TW=1, depth 4).
module tb_mvau_weight_loader;

  logic       aclk = 1'b0;
  logic       areset;
  logic [1:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tlast;
  logic       s_axis_tready;
  logic       reload;
  logic [3:0] wmem_addr;
  logic [1:0] wmem_out;
  logic       wmem_valid;
  logic       load_err;

  int total = 0;
  int bad   = 0;

  mvau_weight_loader #(
    .SIMD         (2),
    .TW           (1),
    .WMEM_DEPTH   (4),
    .WMEM_ADDR_BW (4)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .reload        (reload),
    .wmem_addr     (wmem_addr),
    .wmem_out      (wmem_out),
    .wmem_valid    (wmem_valid),
    .load_err      (load_err)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] d, input logic last);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [1:0] exp, input string tag);
    wmem_addr = a;
    tick();
    check(tag, 32'(wmem_out), 32'(exp));
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic status(input string tag, input logic rdy, input logic vld, input logic err);
    check({tag, "_tready"}, 32'(s_axis_tready), 32'(rdy));
    check({tag, "_valid"}, 32'(wmem_valid), 32'(vld));
    check({tag, "_err"}, 32'(load_err), 32'(err));
  endtask

  initial begin
    areset        = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    reload        = 1'b0;
    wmem_addr     = '0;
    tick();
    check("rst_tready_low", 32'(s_axis_tready), 32'd0);
    tick();
    areset = 1'b0;
    #1;
    status("reset", 1'b1, 1'b0, 1'b0);
    check("reset_out", 32'(wmem_out), 32'd0);

    // Back-to-back load 1,2,3,0.
    send(2'h1, 1'b0);
    send(2'h2, 1'b0);
    send(2'h3, 1'b0);
    status("b2b_mid", 1'b1, 1'b0, 1'b0);
    send(2'h0, 1'b1);
    status("b2b_done", 1'b0, 1'b1, 1'b0);
    rd(4'd0, 2'h1, "b2b_rd0");
    rd(4'd1, 2'h2, "b2b_rd1");
    rd(4'd2, 2'h3, "b2b_rd2");
    rd(4'd3, 2'h0, "b2b_rd3");

    // Gapped load 2,1,0,3 with tvalid low every other cycle.
    do_reload();
    status("reload1", 1'b1, 1'b0, 1'b0);
    tick();
    send(2'h2, 1'b0);
    tick();
    send(2'h1, 1'b0);
    tick();
    send(2'h0, 1'b0);
    tick();
    status("gap_before_last", 1'b1, 1'b0, 1'b0);
    send(2'h3, 1'b1);
    status("gap_done", 1'b0, 1'b1, 1'b0);
    rd(4'd0, 2'h2, "gap_rd0");
    rd(4'd1, 2'h1, "gap_rd1");
    rd(4'd2, 2'h0, "gap_rd2");
    rd(4'd3, 2'h3, "gap_rd3");

    // Early tlast on second word.
    do_reload();
    send(2'h3, 1'b0);
    send(2'h1, 1'b1);
    status("early", 1'b0, 1'b0, 1'b1);
    do_reload();
    status("early_reload", 1'b1, 1'b0, 1'b0);
    send(2'h0, 1'b0);
    send(2'h3, 1'b0);
    send(2'h2, 1'b0);
    send(2'h1, 1'b1);
    status("early_fix", 1'b0, 1'b1, 1'b0);
    rd(4'd0, 2'h0, "fix_rd0");
    rd(4'd1, 2'h3, "fix_rd1");
    rd(4'd3, 2'h1, "fix_rd3");

    // Missing tlast on fourth word; a fifth word must be refused.
    do_reload();
    send(2'h1, 1'b0);
    send(2'h1, 1'b0);
    send(2'h1, 1'b0);
    send(2'h1, 1'b0);
    status("missing", 1'b0, 1'b0, 1'b1);
    send(2'h2, 1'b1);
    status("fifth_refused", 1'b0, 1'b0, 1'b1);
    rd(4'd0, 2'h1, "fifth_rd0");

    // Read-first collision at address 0.
    do_reload();
    send(2'h0, 1'b0);
    send(2'h1, 1'b0);
    send(2'h2, 1'b0);
    send(2'h3, 1'b1);
    status("pre_coll", 1'b0, 1'b1, 1'b0);
    do_reload();
    wmem_addr = 4'd0;
    send(2'h3, 1'b0);
    check("coll_old", 32'(wmem_out), 32'd0);
    tick();
    check("coll_new", 32'(wmem_out), 32'd3);

    // Reload during LOAD must not reset the counter.
    reload = 1'b1;
    send(2'h2, 1'b0);
    reload = 1'b0;
    send(2'h1, 1'b0);
    send(2'h0, 1'b1);
    status("reload_in_load", 1'b0, 1'b1, 1'b0);
    rd(4'd1, 2'h2, "ril_rd1");
    rd(4'd3, 2'h0, "ril_rd3");

    // Asynchronous reset after two words.
    do_reload();
    wmem_addr = 4'd2;
    send(2'h1, 1'b0);
    send(2'h2, 1'b0);
    check("pre_arst_out", 32'(wmem_out), 32'd1);
    #2;
    areset = 1'b1;
    #1;
    status("arst", 1'b0, 1'b0, 1'b0);
    check("arst_out", 32'(wmem_out), 32'd0);
    tick();
    areset = 1'b0;
    #1;
    status("arst_rel", 1'b1, 1'b0, 1'b0);
    send(2'h2, 1'b0);
    send(2'h3, 1'b0);
    send(2'h1, 1'b0);
    status("arst_mid", 1'b1, 1'b0, 1'b0);
    send(2'h0, 1'b1);
    status("arst_done", 1'b0, 1'b1, 1'b0);
    rd(4'd0, 2'h2, "arst_rd0");
    rd(4'd1, 2'h3, "arst_rd1");
    rd(4'd2, 2'h1, "arst_rd2");
    rd(4'd3, 2'h0, "arst_rd3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mvau_weight_loader.md
# mvau_weight_loader

Runtime weight-loading front end for one MVAU PE: accepts weight words on an AXI-Stream slave, writes them sequentially into an internal simple-dual-port weight RAM, and exposes the same synchronous read port the MVAU datapath already uses (address in, SIMD*TW word out, one-cycle latency). It replaces the fixed `$readmemh` ROM when weights are updated at run time. It sits between the host/DMA weight stream and the MVAU compute core.

## Interface
- `SIMD`, 2, input lanes per weight word
- `TW`, 1, bits per weight
- `WMEM_DEPTH`, 4, words per PE memory, equal to (KDim^2·IFMCh·OFMCh)/(SIMD·PE); must be ≥2
- `WMEM_ADDR_BW`, 4, address width; 2^WMEM_ADDR_BW ≥ WMEM_DEPTH
- `aclk` in 1: single clock; all logic on posedge
- `areset` in 1: reset, asynchronous, active-high
- `s_axis_tdata` in SIMD*TW: weight word
- `s_axis_tvalid` in 1: word valid
- `s_axis_tlast` in 1: marks last word of a weight set
- `s_axis_tready` out 1: loader accepts a word
- `reload` in 1: single-cycle request to start a new weight set
- `wmem_addr` in WMEM_ADDR_BW: read address from compute core
- `wmem_out` out SIMD*TW: read data
- `wmem_valid` out 1: complete weight set present
- `load_err` out 1: last weight set had a length mismatch

## Operation
- States: LOAD, READY, ERROR. Reset state: LOAD, write counter 0, `wmem_valid`=0, `load_err`=0, `wmem_out`=0.
- `s_axis_tready` = (state==LOAD) && !`areset`; it is 0 throughout reset.
- Handshake: word accepted when `tvalid`&&`tready` at a clock edge; it is written to RAM at counter address; counter increments.
- LOAD → READY: word accepted at counter = WMEM_DEPTH-1 with `tlast`=1; counter returns to 0, `wmem_valid`←1.
- LOAD → ERROR: `tlast`=1 on an accepted word with counter < WMEM_DEPTH-1 (early), or `tlast`=0 at counter = WMEM_DEPTH-1 (missing). The word is still written; `load_err`←1, `wmem_valid` stays 0, counter←0.
- READY/ERROR → LOAD on `reload`=1: `wmem_valid`←0, `load_err`←0, counter←0. `reload` in LOAD is ignored (no counter reset).
- RAM read port is independent of state; consumer gates use on `wmem_valid`. Contents are not cleared by reset or reload.
- Same-address write and read in one cycle: read-first (old data returned).
- Counter is WMEM_ADDR_BW bits and never exceeds WMEM_DEPTH-1.

## Timing
- Read latency: `wmem_out` reflects RAM[`wmem_addr` sampled at edge N] after edge N; one cycle.
- Write: data accepted at edge N is readable by an address presented at edge N+1 (visible on `wmem_out` after N+1).
- `wmem_valid` rises the cycle after the final accepted word; `load_err` rises the cycle after the offending word.
- `s_axis_tready` drops the cycle after the final/offending word; full throughput (one word/cycle) in LOAD.
- `reload` takes effect at the next edge: `tready` high one cycle after `reload` sampled.
- `areset` mid-load: immediate return to LOAD, counter 0, flags 0; partially written RAM contents retained but invalid.

## Structure
- Shared package `mvau_pkg`: state enum `wload_state_t` {LOAD, READY, ERROR}; no other additions.
- Sub-module `mvau_weight_ram`: simple dual-port RAM (one write port, one registered read port, read-first), `(* ram_style = "auto" *)`, parameters SIMD, TW, WMEM_DEPTH, WMEM_ADDR_BW. Loader holds FSM, counter and flags.

## Test plan
- Reset then stream 4 words 0x1,0x2,0x3,0x0 (SIMD=2,TW=1) back-to-back, `tlast` on 4th -> `wmem_valid`=1 one cycle later, `tready`=0, reads at addr 0..3 return 1,2,3,0 each one cycle after address.
- Same load with `tvalid` toggled every other cycle -> identical contents, counter only advances on handshakes, `wmem_valid` after 4th handshake.
- `tlast` on 2nd word -> `load_err`=1, `wmem_valid`=0, `tready`=0; `reload` pulse -> `load_err`=0, `tready`=1 next cycle; correct 4-word reload -> READY.
- 4th word without `tlast` -> ERROR, `load_err`=1; no 5th word accepted.
- In READY, `reload` then write 0x3 to addr 0 while reading addr 0 the same cycle -> old value returned, 0x3 on the next read.
- Assert `areset` asynchronously after 2 words -> `tready`, `wmem_valid`, `load_err` low immediately; after release a full 4-word load completes normally from addr 0.
